alu_issue_ctrl: RTL and testbench

Sequencer that drives the 16-bit combinational ALU. It accepts operation requests over a valid/ready handshake and reads operands from an internal register file. It presents the operands, opcode and enable to the ALU, then captures the ALU result and carry flag and writes them back. It also converts GTE/LT subtraction outputs into boolean 0/1 results and exposes a host load/inspect port into the register file.

---
 rtl/alu_issue_ctrl.sv | 169 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequencer in front of a 16-bit combinational ALU.
// Accepts one operation at a time over a valid/ready handshake. It reads the
// operands from an internal register file and drives them to the ALU for one
// cycle. It captures the result and carry, then writes back one cycle later.
// A host port loads and inspects the register file while the sequencer is idle.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_op/req_srca/req_srcb/req_dst  operation and register indices
//   done/done_data/done_err        one-cycle writeback completion pulse
//   carry_flag                     sticky carry from last ADD/SUB/GTE/LT
//   host_we/host_addr/host_wdata   host register write (IDLE only)
//   host_rdata                     registered rf[host_addr]
//   alu_en/alu_op1/alu_op2/alu_op  drive to the ALU (active in EXEC only)
//   alu_result/alu_fls             ALU response (only carry flag used)

package alu_issue_pkg;
  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    GTE  = 3'd2,
    LT   = 3'd3,
    NOT  = 3'd4,
    RSV5 = 3'd5,
    RSV6 = 3'd6,
    RSV7 = 3'd7
  } operation_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
  } flags_t;
endpackage

module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  operation_t    req_op,
  input  logic [AW-1:0] req_srca,
  input  logic [AW-1:0] req_srcb,
  input  logic [AW-1:0] req_dst,
  output logic          done,
  output logic [15:0]   done_data,
  output logic          done_err,
  output logic          carry_flag,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [15:0]   host_wdata,
  output logic [15:0]   host_rdata,
  output logic          alu_en,
  output logic [15:0]   alu_op1,
  output logic [15:0]   alu_op2,
  output operation_t    alu_op,
  input  logic [15:0]   alu_result,
  input  flags_t        alu_fls
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  // Only op and dst are needed after EXEC; operand values live in alu_op1/op2.
  typedef struct packed {
    operation_t    op;
    logic [AW-1:0] dst;
  } req_t;

  state_t                 state;
  req_t                   req_q;
  logic [NREGS-1:0][15:0] rf;
  logic [15:0]            res_q;
  logic                   cy_q;

  logic [15:0] op1_n, op2_n, wb_val;
  logic        wb_err, wb_cy_upd;
  logic        accept;

  // Only the carry flag matters; the rest of the flag bundle is ignored.
  logic unused_fls;
  assign unused_fls = ^{alu_fls.zero, alu_fls.neg};

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && (state == IDLE);

  // Operands are registered on the accept edge, so a host write landing on
  // that same edge must be forwarded to match what rf holds during EXEC.
  always_comb begin
    op1_n = (host_we && host_addr == req_srca) ? host_wdata : rf[req_srca];
    op2_n = (host_we && host_addr == req_srcb) ? host_wdata : rf[req_srcb];
    if (req_op == NOT) op2_n = '0;
  end

  // Writeback value; GTE/LT turn the subtraction borrow into a 0/1 result.
  always_comb begin
    wb_val    = '0;
    wb_err    = 1'b0;
    wb_cy_upd = 1'b0;
    case (req_q.op)
      ADD, SUB: begin wb_val = res_q;            wb_cy_upd = 1'b1; end
      GTE:      begin wb_val = {15'd0, ~cy_q};   wb_cy_upd = 1'b1; end
      LT:       begin wb_val = {15'd0, cy_q};    wb_cy_upd = 1'b1; end
      NOT:            wb_val = res_q;
      default:        wb_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_q      <= '{op: ADD, dst: '0};
      rf         <= '0;
      res_q      <= '0;
      cy_q       <= 1'b0;
      carry_flag <= 1'b0;
      done       <= 1'b0;
      done_data  <= '0;
      done_err   <= 1'b0;
      host_rdata <= '0;
      alu_en     <= 1'b0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_op     <= ADD;
    end else begin
      // Read before this edge's writes: shows rf as left by the previous edge.
      host_rdata <= rf[host_addr];
      case (state)
        IDLE: begin
          done     <= 1'b0;
          done_err <= 1'b0;
          if (host_we) rf[host_addr] <= host_wdata;
          if (accept) begin
            req_q   <= '{op: req_op, dst: req_dst};
            alu_en  <= 1'b1;
            alu_op  <= req_op;
            alu_op1 <= op1_n;
            alu_op2 <= op2_n;
            state   <= EXEC;
          end
        end
        EXEC: begin
          res_q   <= alu_result;
          cy_q    <= alu_fls.carry;
          alu_en  <= 1'b0;
          alu_op  <= ADD;
          alu_op1 <= '0;
          alu_op2 <= '0;
          state   <= WB;
        end
        WB: begin
          rf[req_q.dst] <= wb_val;
          if (wb_cy_upd) carry_flag <= cy_q;
          done      <= 1'b1;
          done_data <= wb_val;
          done_err  <= wb_err;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  import alu_issue_pkg::*;

  localparam int NREGS = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  operation_t    req_op;
  logic [AW-1:0] req_srca, req_srcb, req_dst;
  logic          done;
  logic [15:0]   done_data;
  logic          done_err;
  logic          carry_flag;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [15:0]   host_wdata;
  logic [15:0]   host_rdata;
  logic          alu_en;
  logic [15:0]   alu_op1, alu_op2;
  operation_t    alu_op;
  logic [15:0]   alu_result;
  flags_t        alu_fls;

  alu_issue_ctrl #(.NREGS(NREGS), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_srca(req_srca), .req_srcb(req_srcb), .req_dst(req_dst),
    .done(done), .done_data(done_data), .done_err(done_err),
    .carry_flag(carry_flag),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .alu_en(alu_en), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_fls(alu_fls)
  );

  always #5 clk = ~clk;

  // Combinational ALU stand-in. Unsupported ops return junk with carry set,
  // so a controller that wrongly uses them is visible.
  logic [16:0] alu_s;
  always_comb begin
    alu_s      = '0;
    alu_result = '0;
    alu_fls    = '0;
    case (alu_op)
      ADD:          alu_s = {1'b0, alu_op1} + {1'b0, alu_op2};
      SUB, GTE, LT: alu_s = {1'b0, alu_op1} - {1'b0, alu_op2};
      NOT:          alu_s = {1'b0, ~alu_op1};
      default:      alu_s = {1'b1, 16'hDEAD};
    endcase
    alu_result    = alu_s[15:0];
    alu_fls.carry = alu_s[16];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference state: register file and sticky carry.
  logic [15:0] m_rf [NREGS];
  logic        m_carry;

  // Expected writeback from the operation definitions, plain integer math.
  task automatic model(input operation_t op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] v, output logic err);
    int ia, ib;
    ia = int'(a); ib = int'(b);
    err = 1'b0;
    case (op)
      ADD: begin v = 16'((ia + ib) % 65536);         m_carry = (ia + ib) > 65535; end
      SUB: begin v = 16'((ia - ib + 65536) % 65536); m_carry = ia < ib; end
      GTE: begin v = (ia >= ib) ? 16'd1 : 16'd0;     m_carry = ia < ib; end
      LT:  begin v = (ia <  ib) ? 16'd1 : 16'd0;     m_carry = ia < ib; end
      NOT: v = 16'(65535 - ia);
      default: begin v = 16'd0; err = 1'b1; end
    endcase
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_op = ADD; req_srca = '0; req_srcb = '0; req_dst = '0;
    host_we = 0; host_addr = '0; host_wdata = '0;
  endtask

  task automatic host_wr(input int a, input logic [15:0] d);
    @(negedge clk);
    host_we = 1; host_addr = AW'(a); host_wdata = d;
    @(posedge clk); #1;
    host_we = 0;
    m_rf[a] = d;
  endtask

  task automatic rd_chk(input int a);
    @(negedge clk);
    host_addr = AW'(a);
    @(posedge clk); #1;
    chk($sformatf("rf[%0d]", a), 32'(host_rdata), 32'(m_rf[a]));
  endtask

  // One full operation. hw_same: host write to srca on the accept edge
  // (must be honoured). poke: host write to dst during EXEC (must be dropped).
  task automatic run_op(input operation_t op, input int a, input int b, input int d,
                        input bit hw_same, input bit poke);
    logic [15:0] ev, hv;
    logic        ee;
    hv = 16'($urandom);
    @(negedge clk);
    req_valid = 1; req_op = op; req_srca = AW'(a); req_srcb = AW'(b); req_dst = AW'(d);
    if (hw_same) begin host_we = 1; host_addr = AW'(a); host_wdata = hv; end
    chk("ready_idle", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 0; host_we = 0;
    if (hw_same) m_rf[a] = hv;
    chk("ready_exec", 32'(req_ready), 0);
    chk("alu_en_exec", 32'(alu_en), 1);
    chk("alu_op_exec", 32'(alu_op), 32'(op));
    chk("alu_op1", 32'(alu_op1), 32'(m_rf[a]));
    chk("alu_op2", 32'(alu_op2), (op == NOT) ? 32'd0 : 32'(m_rf[b]));
    model(op, m_rf[a], m_rf[b], ev, ee);
    if (poke) begin
      @(negedge clk);
      host_we = 1; host_addr = AW'(d); host_wdata = ~ev;
    end
    @(posedge clk); #1;
    host_we = 0;
    chk("alu_en_wb", 32'(alu_en), 0);
    chk("ready_wb", 32'(req_ready), 0);
    chk("done_early", 32'(done), 0);
    @(posedge clk); #1;
    m_rf[d] = ev;
    chk("done", 32'(done), 1);
    chk("done_data", 32'(done_data), 32'(ev));
    chk("done_err", 32'(done_err), 32'(ee));
    chk("carry_flag", 32'(carry_flag), 32'(m_carry));
    chk("ready_done", 32'(req_ready), 1);
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 0);
  endtask

  typedef struct {
    logic [15:0] v;
    logic        err;
    logic        cy;
  } exp_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        q[$];
    exp_t        e;
    logic [15:0] ev;
    logic        ee, acc;
    int          last, ndone, nacc;

    idle_inputs();
    foreach (m_rf[i]) m_rf[i] = '0;
    m_carry = 0;
    rst_n = 0;
    #23;
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_carry", 32'(carry_flag), 0);
    chk("rst_alu_en", 32'(alu_en), 0);
    chk("rst_alu_ops", {alu_op1, alu_op2}, 0);
    chk("rst_alu_op", 32'(alu_op), 32'(ADD));
    chk("rst_rdata", 32'(host_rdata), 0);
    @(negedge clk); rst_n = 1;

    // ADD with wrap and carry out.
    host_wr(1, 16'hFFFF); host_wr(2, 16'h0001);
    run_op(ADD, 1, 2, 3, 0, 0);
    rd_chk(3);
    // Borrow handling and boolean compares.
    host_wr(1, 16'd3); host_wr(2, 16'd5);
    run_op(SUB, 1, 2, 4, 0, 0);
    run_op(LT,  1, 2, 6, 0, 0);
    run_op(GTE, 1, 2, 7, 0, 0);
    run_op(GTE, 2, 1, 0, 0, 0);
    rd_chk(4); rd_chk(6); rd_chk(7); rd_chk(0);
    // NOT in place with carry=1 kept.
    host_wr(5, 16'h00F0);
    run_op(SUB, 1, 2, 6, 0, 0);
    run_op(NOT, 5, 3, 5, 0, 0);
    rd_chk(5);
    // Unsupported op: carry 0 must survive the ALU's junk carry.
    run_op(ADD, 2, 1, 3, 0, 0);
    run_op(RSV6, 1, 2, 4, 0, 0);
    run_op(RSV7, 1, 1, 6, 0, 0);
    rd_chk(4);
    // Same source twice, dst aliasing source, host write on accept edge, write during EXEC.
    run_op(ADD, 2, 2, 2, 0, 0);
    run_op(SUB, 3, 3, 3, 1, 0);
    run_op(ADD, 1, 2, 7, 0, 1);
    rd_chk(7); rd_chk(3);

    // Random operations.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) host_wr($urandom_range(0, NREGS-1), 16'($urandom));
      run_op(operation_t'($urandom_range(0, 7)), $urandom_range(0, NREGS-1),
             $urandom_range(0, NREGS-1), $urandom_range(0, NREGS-1),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end
    for (int i = 0; i < NREGS; i++) rd_chk(i);

    // Back-to-back: req_valid held high, host writes every cycle.
    last = -1; ndone = 0; nacc = 0;
    @(negedge clk);
    req_valid = 1;
    req_op = operation_t'($urandom_range(0, 7));
    req_srca = AW'($urandom); req_srcb = AW'($urandom); req_dst = AW'($urandom);
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cyc > 0) @(negedge clk);
      host_we = 1; host_addr = AW'($urandom); host_wdata = 16'($urandom);
      acc = req_ready;
      if (acc) begin
        m_rf[host_addr] = host_wdata;
        model(req_op, m_rf[req_srca], m_rf[req_srcb], ev, ee);
        m_rf[req_dst] = ev;
        q.push_back('{v: ev, err: ee, cy: m_carry});
        if (last >= 0) chk("issue_gap", 32'(cyc - last), 3);
        last = cyc; nacc++;
      end
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (q.size() == 0) chk("spurious_done", 32'(done), 0);
        else begin
          e = q.pop_front();
          chk("bb_data", 32'(done_data), 32'(e.v));
          chk("bb_err", 32'(done_err), 32'(e.err));
          chk("bb_carry", 32'(carry_flag), 32'(e.cy));
        end
      end
      if (acc) begin
        req_op = operation_t'($urandom_range(0, 7));
        req_srca = AW'($urandom); req_srcb = AW'($urandom); req_dst = AW'($urandom);
      end
    end
    @(negedge clk);
    req_valid = 0; host_we = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (q.size() == 0) chk("spurious_done", 32'(done), 0);
        else begin
          e = q.pop_front();
          chk("bb_data", 32'(done_data), 32'(e.v));
          chk("bb_err", 32'(done_err), 32'(e.err));
        end
      end
    end
    chk("bb_accepts", 32'(nacc), 20);
    chk("bb_dones", 32'(ndone), 20);
    for (int i = 0; i < NREGS; i++) rd_chk(i);

    // Reset in the middle of EXEC aborts everything.
    host_wr(1, 16'h1234);
    @(negedge clk);
    req_valid = 1; req_op = ADD; req_srca = 1; req_srcb = 1; req_dst = 2;
    @(posedge clk); #1;
    req_valid = 0;
    chk("pre_rst_en", 32'(alu_en), 1);
    rst_n = 0; #1;
    chk("mid_rst_ready", 32'(req_ready), 1);
    chk("mid_rst_en", 32'(alu_en), 0);
    chk("mid_rst_carry", 32'(carry_flag), 0);
    foreach (m_rf[i]) m_rf[i] = '0;
    m_carry = 0;
    @(negedge clk); rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("no_done_after_rst", 32'(done), 0);
    end
    rd_chk(1); rd_chk(2);
    host_wr(1, 16'h8000); host_wr(2, 16'h8001);
    run_op(ADD, 1, 2, 3, 0, 0);
    rd_chk(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
